vu_level_ctrl: RTL
==================

VU_LEVEL_CTRL -- requirements
Module: vu_level_ctrl

Interface
REQ-001 SHALL have parameter LVL_W, default 9, level word width.
REQ-002 SHALL have parameter HOLD_FRAMES, default 30, peak-hold duration in frames.
REQ-003 SHALL have parameter DECAY_STEP, default 4, per-frame fall of bar and peak.
REQ-004 SHALL have parameter V_POL, default 0, v_sync polarity (0 = sync on 0, 1 = sync on 1).
REQ-005 pixel_clock  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 v_sync  in  1  vertical sync from the timing generator, pixel_clock domain.
REQ-008 smp_valid  in  1  sample offered.
REQ-009 smp_ready  out  1  sample accepted when smp_valid and smp_ready are both 1.
REQ-010 smp_level  in  LVL_W  unsigned audio magnitude.
REQ-011 bar_level  out  LVL_W  bar height for the renderer, stable for the whole frame.
REQ-012 peak_level  out  LVL_W  peak marker height, stable for the whole frame.
REQ-013 frame_upd  out  1  one-cycle pulse when bar_level/peak_level take new values.
REQ-014 clip  out  1  previous frame contained a full-scale sample.

Function
REQ-015 Frame tick SHALL be one pulse on the first cycle v_sync is sampled at V_POL after being !V_POL (registered edge detect).
REQ-016 FSM states SHALL be IDLE, ACCUM, COMMIT; IDLE->ACCUM on first frame tick; ACCUM->COMMIT on frame tick; COMMIT->ACCUM unconditionally after one cycle.
REQ-017 smp_ready SHALL be 1 only in ACCUM.
REQ-018 In ACCUM, each accepted sample SHALL update acc_max = max(acc_max, smp_level).
REQ-019 A sample accepted in the same cycle as the frame tick SHALL be included in the frame being committed.
REQ-020 In COMMIT: new_bar = acc_max if acc_max >= bar_level, else max(bar_level - DECAY_STEP saturating at 0, acc_max).
REQ-021 Peak: if new_bar >= peak_level then peak = new_bar and hold_cnt = HOLD_FRAMES; else if hold_cnt > 0 then hold_cnt decrements and peak is held; else peak = max(peak_level - DECAY_STEP saturating at 0, new_bar).
REQ-022 acc_max SHALL be cleared to 0 on COMMIT exit.
REQ-023 Latency: frame tick at edge k -> COMMIT during cycle k..k+1 -> bar_level, peak_level and frame_upd updated at edge k+1; frame_upd high exactly one cycle.
REQ-024 A frame tick occurring in COMMIT or IDLE->ACCUM transition cycle SHALL be ignored, except as the IDLE exit.
REQ-025 All arithmetic SHALL be LVL_W bits unsigned; no wrap-around below 0 or above 2^LVL_W-1.
REQ-026 No samples are accepted in IDLE; bar_level and peak_level remain 0 there.

Reset
REQ-027 While reset_n = 0: state IDLE, smp_ready 0, bar_level 0, peak_level 0, frame_upd 0, clip 0, acc_max 0, hold_cnt 0, v_sync history !V_POL.
REQ-028 Reset asserted mid-frame SHALL discard acc_max; first commit after release requires a fresh IDLE exit plus one full frame.

Configuration
REQ-029 Macro VU_LEVEL_CLIP_EN defined: clip_acc set on any accepted sample equal to 2^LVL_W-1, copied to clip in COMMIT, cleared on COMMIT exit.
REQ-030 Macro VU_LEVEL_CLIP_EN undefined: clip port present and tied to 0; no clip registers synthesized.

Structure
REQ-031 Shared package vu_pkg SHALL hold the FSM state typedef, default LVL_W and the saturating-subtract helper function.
REQ-032 Peak-hold logic (REQ-021) SHALL be a sub-module vu_peak_hold with inputs new_bar and commit strobe.

Verification
REQ-033 Reset, then v_sync low pulse (V_POL 0), samples 10,200,50 -> next tick: bar 200, peak 200, frame_upd single pulse.
REQ-034 Following frame no samples -> bar 196, peak 200; repeated empty frames -> peak held 30 frames, then falls 4/frame, never below bar, never below 0.
REQ-035 smp_valid held 1 across frame tick -> smp_ready low exactly one cycle (COMMIT); sample on tick cycle counted in old frame.
REQ-036 Sample 511 with VU_LEVEL_CLIP_EN -> clip 1 for one frame then 0; without macro -> clip always 0.
REQ-037 reset_n low mid-ACCUM with acc_max 300 -> all outputs 0 asynchronously; no commit until IDLE exit plus next tick.
REQ-038 bar 2, empty frame -> bar 0 (saturation), no wrap to 510.

Source files
------------

// File: rtl/vu_pkg.sv
// -----------------------------------------------------------------------------
// vu_pkg
// Shared definitions for the VU level controller slice:
//   vu_state_t  - frame FSM state encoding (IDLE, ACCUM, COMMIT)
//   LVL_W_DEF   - default level word width
//   sat_sub()   - unsigned subtract clamped at zero
// -----------------------------------------------------------------------------
package vu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } vu_state_t;

    localparam int unsigned LVL_W_DEF = 9;

    // Callers zero-extend their operands to 32 bits and truncate the result
    // back to their own width.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// -----------------------------------------------------------------------------
// vu_peak_hold
// Peak marker with hold-then-decay behaviour, advanced once per commit strobe.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   commit     in   one-cycle strobe, evaluate the new bar value
//   new_bar    in   bar value being committed this frame
//   peak_level out  current peak marker height
// -----------------------------------------------------------------------------
module vu_peak_hold
    import vu_pkg::*;
#(
    parameter int unsigned LVL_W       = LVL_W_DEF,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  logic [LVL_W-1:0] new_bar,
    output logic [LVL_W-1:0] peak_level
);

    localparam int unsigned HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    logic [HW-1:0]    hold_cnt;
    logic [LVL_W-1:0] peak_decay;

    assign peak_decay = LVL_W'(sat_sub(32'(peak_level), DECAY_STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_level <= '0;
            hold_cnt   <= '0;
        end else if (commit) begin
            if (new_bar >= peak_level) begin
                peak_level <= new_bar;
                hold_cnt   <= HW'(HOLD_FRAMES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end else begin
                // Decaying peak never drops below the bar it marks.
                peak_level <= (peak_decay > new_bar) ? peak_decay : new_bar;
            end
        end
    end

endmodule

// File: rtl/vu_level_ctrl.sv
// -----------------------------------------------------------------------------
// vu_level_ctrl
// Per-frame VU meter level controller: collects the maximum accepted sample
// magnitude over a video frame and, on each vertical sync, commits a decaying
// bar level and a held/decaying peak marker for the renderer.
// Ports:
//   pixel_clock in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   v_sync      in   vertical sync (active level set by V_POL)
//   smp_valid   in   sample offered
//   smp_ready   out  sample accepted when smp_valid && smp_ready
//   smp_level   in   unsigned sample magnitude
//   bar_level   out  bar height, stable for a whole frame
//   peak_level  out  peak marker height, stable for a whole frame
//   frame_upd   out  one-cycle pulse when bar/peak take new values
//   clip        out  previous frame contained a full-scale sample
// Build option:
//   VU_LEVEL_CLIP_EN  defined -> clip detection; undefined -> clip tied to 0
// -----------------------------------------------------------------------------
module vu_level_ctrl
    import vu_pkg::*;
#(
    parameter int unsigned LVL_W       = LVL_W_DEF,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY_STEP  = 4,
    parameter bit          V_POL       = 1'b0
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    input  logic             v_sync,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic [LVL_W-1:0] smp_level,
    output logic [LVL_W-1:0] bar_level,
    output logic [LVL_W-1:0] peak_level,
    output logic             frame_upd,
    output logic             clip
);

    vu_state_t        state;
    logic             v_prev;
    logic             tick;
    logic             accept;
    logic             commit;
    logic [LVL_W-1:0] acc_max;
    logic [LVL_W-1:0] bar_decay;
    logic [LVL_W-1:0] new_bar;

    assign tick      = (v_sync == V_POL) && (v_prev != V_POL);
    assign accept    = smp_valid && smp_ready;
    assign commit    = (state == COMMIT);
    assign bar_decay = LVL_W'(sat_sub(32'(bar_level), DECAY_STEP));

    always_comb begin
        new_bar = acc_max;
        if (acc_max < bar_level) begin
            new_bar = (bar_decay > acc_max) ? bar_decay : acc_max;
        end
    end

    // A sample accepted on the tick edge still lands in acc_max before COMMIT
    // reads it, so it belongs to the frame being committed.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            v_prev    <= !V_POL;
            smp_ready <= 1'b0;
            bar_level <= '0;
            frame_upd <= 1'b0;
            acc_max   <= '0;
        end else begin
            v_prev    <= v_sync;
            frame_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= ACCUM;
                        smp_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept && (smp_level > acc_max)) begin
                        acc_max <= smp_level;
                    end
                    if (tick) begin
                        state     <= COMMIT;
                        smp_ready <= 1'b0;
                    end
                end
                COMMIT: begin
                    bar_level <= new_bar;
                    frame_upd <= 1'b1;
                    acc_max   <= '0;
                    state     <= ACCUM;
                    smp_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    smp_ready <= 1'b0;
                end
            endcase
        end
    end

    vu_peak_hold #(
        .LVL_W      (LVL_W),
        .HOLD_FRAMES(HOLD_FRAMES),
        .DECAY_STEP (DECAY_STEP)
    ) u_peak_hold (
        .clk       (pixel_clock),
        .rst_n     (reset_n),
        .commit    (commit),
        .new_bar   (new_bar),
        .peak_level(peak_level)
    );

`ifdef VU_LEVEL_CLIP_EN
    logic clip_acc;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            clip_acc <= 1'b0;
            clip     <= 1'b0;
        end else begin
            if ((state == ACCUM) && accept && (smp_level == '1)) begin
                clip_acc <= 1'b1;
            end
            if (commit) begin
                clip     <= clip_acc;
                clip_acc <= 1'b0;
            end
        end
    end
`else
    assign clip = 1'b0;
`endif

endmodule
